// File: rtl/qos_vc_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : qos_vc_dispatch
// Description : Two-VC dispatcher; routes each word by its class bit into a
//               per-channel 2-entry elastic buffer with delivery/stall stats.
// Revision    : 1.0 - initial release
// ============================================================================
module qos_vc_dispatch #(
    parameter int WIDTH     = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enb,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic                 pause_0,
    input  logic                 pause_1,
    output logic [WIDTH-1:0]     data_out_0,
    output logic [WIDTH-1:0]     data_out_1,
    output logic                 valid_out_0,
    output logic                 valid_out_1,
    output logic [CNT_WIDTH-1:0] count_0,
    output logic [CNT_WIDTH-1:0] count_1,
    output logic [CNT_WIDTH-1:0] stall_0,
    output logic [CNT_WIDTH-1:0] stall_1
);

    localparam logic [1:0]           c_ST_EMPTY = 2'd0;
    localparam logic [1:0]           c_ST_ONE   = 2'd1;
    localparam logic [1:0]           c_ST_TWO   = 2'd2;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = {CNT_WIDTH{1'b1}};

    logic                      w_sel;
    logic [1:0]                w_pause;
    logic [1:0][1:0]           w_state;
    logic [1:0][WIDTH-1:0]     w_head;
    logic [1:0]                w_valid;
    logic [1:0][CNT_WIDTH-1:0] w_count;
    logic [1:0][CNT_WIDTH-1:0] w_stall;

    assign w_sel    = enb & data_in[WIDTH-1];
    assign w_pause  = {pause_1, pause_0};
    // Readiness follows the channel the presented word would land in.
    assign ready_in = (w_state[w_sel] != c_ST_TWO);

    for (genvar k = 0; k < 2; k++) begin : g_vc
        logic [1:0]           r_state;
        logic [1:0]           w_state_nxt;
        logic [WIDTH-1:0]     r_head;
        logic [WIDTH-1:0]     r_skid;
        logic [CNT_WIDTH-1:0] r_count;
        logic [CNT_WIDTH-1:0] r_stall;
        logic                 w_push;
        logic                 w_pop;
        logic                 w_vld;
        logic                 w_ld_head_in;
        logic                 w_ld_head_skid;
        logic                 w_ld_skid;

        assign w_vld  = (r_state != c_ST_EMPTY);
        assign w_push = valid_in & ready_in & (w_sel == 1'(k));
        assign w_pop  = w_vld & ~w_pause[k];

        always_comb begin
            w_state_nxt    = r_state;
            w_ld_head_in   = 1'b0;
            w_ld_head_skid = 1'b0;
            w_ld_skid      = 1'b0;
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt  = c_ST_ONE;
                        w_ld_head_in = 1'b1;
                    end
                end
                c_ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_ld_head_in = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = c_ST_TWO;
                        w_ld_skid   = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = c_ST_EMPTY;
                    end
                end
                c_ST_TWO: begin
                    if (w_pop) begin
                        w_state_nxt    = c_ST_ONE;
                        w_ld_head_skid = 1'b1;
                    end
                end
                default: w_state_nxt = c_ST_EMPTY;
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= c_ST_EMPTY;
                r_head  <= '0;
                r_skid  <= '0;
                r_count <= '0;
                r_stall <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (w_ld_head_in) begin
                    r_head <= data_in;
                end else if (w_ld_head_skid) begin
                    r_head <= r_skid;
                end
                if (w_ld_skid) begin
                    r_skid <= data_in;
                end
                if (w_pop) begin
                    r_count <= r_count + 1'b1;
                end
                if (w_vld && w_pause[k] && (r_stall != c_CNT_MAX)) begin
                    r_stall <= r_stall + 1'b1;
                end
            end
        end

        assign w_state[k] = r_state;
        assign w_head[k]  = r_head;
        assign w_valid[k] = w_vld;
        assign w_count[k] = r_count;
        assign w_stall[k] = r_stall;
    end

    assign data_out_0  = w_head[0];
    assign data_out_1  = w_head[1];
    assign valid_out_0 = w_valid[0];
    assign valid_out_1 = w_valid[1];
    assign count_0     = w_count[0];
    assign count_1     = w_count[1];
    assign stall_0     = w_stall[0];
    assign stall_1     = w_stall[1];

endmodule
`default_nettype wire

// File: tb/tb_qos_vc_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_qos_vc_dispatch
// Description : Directed vector table plus hand sequences for qos_vc_dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qos_vc_dispatch;

    localparam int WIDTH     = 6;
    localparam int CNT_WIDTH = 8;

    logic                 clk;
    logic                 reset;
    logic                 enb;
    logic [WIDTH-1:0]     data_in;
    logic                 valid_in;
    logic                 ready_in;
    logic                 pause_0;
    logic                 pause_1;
    logic [WIDTH-1:0]     data_out_0;
    logic [WIDTH-1:0]     data_out_1;
    logic                 valid_out_0;
    logic                 valid_out_1;
    logic [CNT_WIDTH-1:0] count_0;
    logic [CNT_WIDTH-1:0] count_1;
    logic [CNT_WIDTH-1:0] stall_0;
    logic [CNT_WIDTH-1:0] stall_1;

    qos_vc_dispatch #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enb         (enb),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .pause_0     (pause_0),
        .pause_1     (pause_1),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .count_0     (count_0),
        .count_1     (count_1),
        .stall_0     (stall_0),
        .stall_1     (stall_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       vin;
        logic [5:0] din;
        logic       p0;
        logic       p1;
        logic       chk_rdy;
        logic       rdy;
        logic       v0;
        logic [5:0] d0;
        logic       v1;
        logic [5:0] d1;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] s0;
        logic [7:0] s1;
    } vec_t;

    localparam int c_NVEC = 22;
    vec_t vec [c_NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic vin,
                         input logic [5:0] din, input logic p0, input logic p1);
        @(negedge clk);
        reset    = rst;
        enb      = en;
        valid_in = vin;
        data_in  = din;
        pause_0  = p0;
        pause_1  = p1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enb = 1'b0; valid_in = 1'b0; data_in = '0;
        pause_0 = 1'b0; pause_1 = 1'b0;

        //            rst en vin din    p0 p1 crdy rdy v0 d0     v1 d1     c0  c1 s0 s1
        vec[0]  = '{1'b1,1'b0,1'b0,6'h00,1'b0,1'b0,1'b0,1'b0,1'b0,6'h00,1'b0,6'h00,8'd0, 8'd0,8'd0,8'd0};
        // enb=1 stream alternating classes, no pause
        vec[1]  = '{1'b0,1'b1,1'b1,6'h01,1'b0,1'b0,1'b1,1'b1,1'b1,6'h01,1'b0,6'h00,8'd0, 8'd0,8'd0,8'd0};
        vec[2]  = '{1'b0,1'b1,1'b1,6'h22,1'b0,1'b0,1'b1,1'b1,1'b0,6'h01,1'b1,6'h22,8'd1, 8'd0,8'd0,8'd0};
        vec[3]  = '{1'b0,1'b1,1'b1,6'h03,1'b0,1'b0,1'b1,1'b1,1'b1,6'h03,1'b0,6'h22,8'd1, 8'd1,8'd0,8'd0};
        vec[4]  = '{1'b0,1'b1,1'b1,6'h24,1'b0,1'b0,1'b1,1'b1,1'b0,6'h03,1'b1,6'h24,8'd2, 8'd1,8'd0,8'd0};
        vec[5]  = '{1'b0,1'b1,1'b0,6'h00,1'b0,1'b0,1'b1,1'b1,1'b0,6'h03,1'b0,6'h24,8'd2, 8'd2,8'd0,8'd0};
        // enb=0: class bit ignored, all to VC0
        vec[6]  = '{1'b0,1'b0,1'b1,6'h21,1'b0,1'b0,1'b1,1'b1,1'b1,6'h21,1'b0,6'h24,8'd2, 8'd2,8'd0,8'd0};
        vec[7]  = '{1'b0,1'b0,1'b1,6'h22,1'b0,1'b0,1'b1,1'b1,1'b1,6'h22,1'b0,6'h24,8'd3, 8'd2,8'd0,8'd0};
        vec[8]  = '{1'b0,1'b0,1'b0,6'h00,1'b0,1'b0,1'b1,1'b1,1'b0,6'h22,1'b0,6'h24,8'd4, 8'd2,8'd0,8'd0};
        // pause_0 held: two accepted, third blocked, then release
        vec[9]  = '{1'b0,1'b1,1'b1,6'h01,1'b1,1'b0,1'b1,1'b1,1'b1,6'h01,1'b0,6'h24,8'd4, 8'd2,8'd0,8'd0};
        vec[10] = '{1'b0,1'b1,1'b1,6'h02,1'b1,1'b0,1'b1,1'b1,1'b1,6'h01,1'b0,6'h24,8'd4, 8'd2,8'd1,8'd0};
        vec[11] = '{1'b0,1'b1,1'b1,6'h03,1'b1,1'b0,1'b1,1'b0,1'b1,6'h01,1'b0,6'h24,8'd4, 8'd2,8'd2,8'd0};
        vec[12] = '{1'b0,1'b1,1'b1,6'h03,1'b1,1'b0,1'b1,1'b0,1'b1,6'h01,1'b0,6'h24,8'd4, 8'd2,8'd3,8'd0};
        vec[13] = '{1'b0,1'b1,1'b1,6'h03,1'b0,1'b0,1'b1,1'b0,1'b1,6'h02,1'b0,6'h24,8'd5, 8'd2,8'd3,8'd0};
        vec[14] = '{1'b0,1'b1,1'b1,6'h03,1'b0,1'b0,1'b1,1'b1,1'b1,6'h03,1'b0,6'h24,8'd6, 8'd2,8'd3,8'd0};
        vec[15] = '{1'b0,1'b1,1'b0,6'h00,1'b0,1'b0,1'b1,1'b1,1'b0,6'h03,1'b0,6'h24,8'd7, 8'd2,8'd3,8'd0};
        // VC1 filled to TWO under pause_1 while VC0 streams at full rate
        vec[16] = '{1'b0,1'b1,1'b1,6'h21,1'b0,1'b1,1'b1,1'b1,1'b0,6'h03,1'b1,6'h21,8'd7, 8'd2,8'd3,8'd0};
        vec[17] = '{1'b0,1'b1,1'b1,6'h22,1'b0,1'b1,1'b1,1'b1,1'b0,6'h03,1'b1,6'h21,8'd7, 8'd2,8'd3,8'd1};
        vec[18] = '{1'b0,1'b1,1'b1,6'h05,1'b0,1'b1,1'b1,1'b1,1'b1,6'h05,1'b1,6'h21,8'd7, 8'd2,8'd3,8'd2};
        vec[19] = '{1'b0,1'b1,1'b1,6'h06,1'b0,1'b1,1'b1,1'b1,1'b1,6'h06,1'b1,6'h21,8'd8, 8'd2,8'd3,8'd3};
        vec[20] = '{1'b0,1'b1,1'b1,6'h07,1'b0,1'b1,1'b1,1'b1,1'b1,6'h07,1'b1,6'h21,8'd9, 8'd2,8'd3,8'd4};
        vec[21] = '{1'b0,1'b1,1'b0,6'h00,1'b0,1'b1,1'b1,1'b1,1'b0,6'h07,1'b1,6'h21,8'd10,8'd2,8'd3,8'd5};

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vec[i].rst, vec[i].en, vec[i].vin, vec[i].din, vec[i].p0, vec[i].p1);
            if (vec[i].chk_rdy) chk($sformatf("v%0d ready_in", i), ready_in, vec[i].rdy);
            tick();
            chk($sformatf("v%0d valid_out_0", i), valid_out_0, vec[i].v0);
            chk($sformatf("v%0d data_out_0", i), data_out_0, vec[i].d0);
            chk($sformatf("v%0d valid_out_1", i), valid_out_1, vec[i].v1);
            chk($sformatf("v%0d data_out_1", i), data_out_1, vec[i].d1);
            chk($sformatf("v%0d count_0", i), count_0, vec[i].c0);
            chk($sformatf("v%0d count_1", i), count_1, vec[i].c1);
            chk($sformatf("v%0d stall_0", i), stall_0, vec[i].s0);
            chk($sformatf("v%0d stall_1", i), stall_1, vec[i].s1);
        end

        // Fill VC0 to TWO as well (VC1 still TWO), then reset mid-operation
        drive(1'b0, 1'b1, 1'b1, 6'h11, 1'b1, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b1, 6'h12, 1'b1, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b1, 6'h13, 1'b1, 1'b1);
        chk("both_two ready vc0", ready_in, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 6'h33, 1'b1, 1'b1);
        chk("both_two ready vc1", ready_in, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 6'h14, 1'b0, 1'b0); tick();
        chk("rst valid_out_0", valid_out_0, 1'b0);
        chk("rst valid_out_1", valid_out_1, 1'b0);
        chk("rst data_out_0", data_out_0, 6'h00);
        chk("rst data_out_1", data_out_1, 6'h00);
        chk("rst count_0", count_0, 8'd0);
        chk("rst count_1", count_1, 8'd0);
        chk("rst stall_0", stall_0, 8'd0);
        chk("rst stall_1", stall_1, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
        chk("post_rst ready_in", ready_in, 1'b1);
        tick();
        chk("post_rst valid_out_0", valid_out_0, 1'b0);
        chk("post_rst valid_out_1", valid_out_1, 1'b0);
        chk("post_rst count_0", count_0, 8'd0);
        chk("post_rst count_1", count_1, 8'd0);

        // Stall saturation: one word parked under pause for 300 cycles
        drive(1'b0, 1'b1, 1'b1, 6'h0A, 1'b1, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0);
        repeat (300) tick();
        chk("sat stall_0", stall_0, 8'd255);
        chk("sat valid_out_0", valid_out_0, 1'b1);
        chk("sat data_out_0", data_out_0, 6'h0A);
        chk("sat count_0", count_0, 8'd0);

        // Count wrap: 0x0A plus 255 streamed words = 256 deliveries
        for (int i = 1; i <= 255; i++) begin
            drive(1'b0, 1'b1, 1'b1, 6'(i & 32'h1F), 1'b0, 1'b0);
            tick();
        end
        chk("wrap pre count_0", count_0, 8'd255);
        chk("wrap pre data_out_0", data_out_0, 6'h1F);
        drive(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0); tick();
        chk("wrap count_0", count_0, 8'd0);
        chk("wrap valid_out_0", valid_out_0, 1'b0);
        chk("wrap stall_0 held", stall_0, 8'd255);
        chk("wrap count_1", count_1, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
